// File: rtl/idma_pkg.sv
// Shared types and defaults for the iDMA lane buffer.
package idma_pkg;

    typedef logic [7:0] byte_t;

    localparam int unsigned IdmaLaneBufferDepth = 3;

    // Pointer width for a FIFO of the given depth; never less than one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/idma_lane_fifo.sv
// Single-byte-wide FIFO for one lane of the iDMA lane buffer.
module idma_lane_fifo
    import idma_pkg::*;
#(
    parameter int unsigned Depth = IdmaLaneBufferDepth
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  clear_i,
    input  byte_t data_i,
    input  logic  valid_i,
    output logic  ready_o,
    output byte_t data_o,
    output logic  valid_o,
    input  logic  ready_i
);

    localparam int unsigned PtrWidth = ptr_width(Depth);
    localparam int unsigned CntWidth = $clog2(Depth + 1);
    localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 1);
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);

    byte_t                mem_q [Depth];
    logic  [PtrWidth-1:0] wptr_q, wptr_d;
    logic  [PtrWidth-1:0] rptr_q, rptr_d;
    logic  [CntWidth-1:0] count_q, count_d;
    logic                 push, pop;

    assign ready_o = (count_q != DepthCnt);
    assign valid_o = (count_q != '0);
    assign data_o  = mem_q[rptr_q];
    assign push    = valid_i & ready_o;
    assign pop     = valid_o & ready_i;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        // Explicit wrap: Depth need not be a power of two.
        if (push) wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + PtrWidth'(1);
        if (pop)  rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + PtrWidth'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CntWidth'(1);
            2'b01:   count_d = count_q - CntWidth'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately left unreset; stale bytes are hidden by valid_o.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/idma_lane_buffer.sv
// Per-byte-lane FIFO bank between the AXIS read task and the write task.
module idma_lane_buffer
    import idma_pkg::*;
#(
    parameter int unsigned StrbWidth = 16,
    parameter int unsigned Depth     = IdmaLaneBufferDepth,
    parameter type         strb_t    = logic [StrbWidth-1:0]
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  byte_t [StrbWidth-1:0] data_i,
    input  strb_t                 valid_i,
    output strb_t                 ready_o,
    output byte_t [StrbWidth-1:0] data_o,
    output strb_t                 valid_o,
    input  strb_t                 ready_i,
    output logic                  empty_o
);

    if (Depth < 2) begin : gen_depth_check
        $error("idma_lane_buffer: Depth must be at least 2");
    end
    if (StrbWidth < 1) begin : gen_width_check
        $error("idma_lane_buffer: StrbWidth must be at least 1");
    end

    for (genvar i = 0; i < StrbWidth; i++) begin : gen_lane
        idma_lane_fifo #(
            .Depth (Depth)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .clear_i (clear_i),
            .data_i  (data_i[i]),
            .valid_i (valid_i[i]),
            .ready_o (ready_o[i]),
            .data_o  (data_o[i]),
            .valid_o (valid_o[i]),
            .ready_i (ready_i[i])
        );
    end

    // valid_o comes straight from registered counts, so this has no input path.
    assign empty_o = ~|valid_o;

endmodule

// File: tb/tb_idma_lane_buffer.sv
// Directed self-checking bench for idma_lane_buffer (StrbWidth=16, Depth=3).
module tb_idma_lane_buffer;

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic [15:0][7:0] data_in;
    logic [15:0]      valid_in;
    logic [15:0]      ready_out;
    logic [15:0][7:0] data_out;
    logic [15:0]      valid_out;
    logic [15:0]      ready_in;
    logic             empty;

    int tests_run = 0;
    int tests_failed = 0;

    idma_lane_buffer #(
        .StrbWidth (16),
        .Depth     (3)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clear_i (clear),
        .data_i  (data_in),
        .valid_i (valid_in),
        .ready_o (ready_out),
        .data_o  (data_out),
        .valid_o (valid_out),
        .ready_i (ready_in),
        .empty_o (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        clear    = 1'b0;
        data_in  = '0;
        valid_in = '0;
        ready_in = '0;

        // Reset held for two cycles.
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_valid", 32'(valid_out), 32'h0000);
        chk("rst_ready", 32'(ready_out), 32'hFFFF);
        chk("rst_empty", 32'(empty), 32'h1);

        // Single push / pop on lane 3.
        data_in[3] = 8'hA5;
        valid_in   = 16'h0008;
        tick();
        valid_in = '0;
        chk("l3_valid", 32'(valid_out), 32'h0008);
        chk("l3_data", 32'(data_out[3]), 32'hA5);
        chk("l3_empty", 32'(empty), 32'h0);
        chk("l3_ready", 32'(ready_out), 32'hFFFF);
        ready_in = 16'h0008;
        tick();
        ready_in = '0;
        chk("l3_pop_valid", 32'(valid_out), 32'h0000);
        chk("l3_pop_empty", 32'(empty), 32'h1);

        // Fill lane 0 to Depth, then an extra push must be refused.
        valid_in   = 16'h0001;
        data_in[0] = 8'h11;
        tick();
        chk("l0_ready_1", 32'(ready_out), 32'hFFFF);
        data_in[0] = 8'h22;
        tick();
        chk("l0_ready_2", 32'(ready_out), 32'hFFFF);
        data_in[0] = 8'h33;
        tick();
        chk("l0_full_ready", 32'(ready_out), 32'hFFFE);
        data_in[0] = 8'h44;
        tick();
        chk("l0_overflow_ready", 32'(ready_out), 32'hFFFE);
        chk("l0_head", 32'(data_out[0]), 32'h11);

        // Full lane with push+pop: pop only, 0x55 must never appear.
        data_in[0] = 8'h55;
        ready_in   = 16'h0001;
        tick();
        valid_in = '0;
        ready_in = '0;
        chk("l0_fullpp_ready", 32'(ready_out), 32'hFFFF);
        chk("l0_fullpp_head", 32'(data_out[0]), 32'h22);
        ready_in = 16'h0001;
        tick();
        chk("l0_pop_33", 32'(data_out[0]), 32'h33);
        chk("l0_pop_33_valid", 32'(valid_out), 32'h0001);
        tick();
        ready_in = '0;
        chk("l0_drained", 32'(valid_out), 32'h0000);

        // Stream 10 bytes through lane 7, pushing and popping every cycle.
        valid_in = 16'h0080;
        ready_in = 16'h0080;
        for (int k = 0; k < 10; k++) begin
            data_in[7] = 8'(k);
            tick();
            chk($sformatf("l7_data_%0d", k), 32'(data_out[7]), 32'(k));
            chk($sformatf("l7_valid_%0d", k), 32'(valid_out), 32'h0080);
            chk($sformatf("l7_ready_%0d", k), 32'(ready_out), 32'hFFFF);
        end
        valid_in = '0;
        tick();
        ready_in = '0;
        chk("l7_drained", 32'(valid_out), 32'h0000);

        // Two bytes each into lanes 1 and 2, then clear with a same-cycle push.
        valid_in   = 16'h0006;
        data_in[1] = 8'hA1;
        data_in[2] = 8'hB1;
        tick();
        data_in[1] = 8'hA2;
        data_in[2] = 8'hB2;
        tick();
        chk("fill12_valid", 32'(valid_out), 32'h0006);
        chk("fill12_head1", 32'(data_out[1]), 32'hA1);
        chk("fill12_head2", 32'(data_out[2]), 32'hB1);
        clear      = 1'b1;
        valid_in   = 16'h0002;
        data_in[1] = 8'hCC;
        tick();
        clear    = 1'b0;
        valid_in = '0;
        chk("clr_valid", 32'(valid_out), 32'h0000);
        chk("clr_ready", 32'(ready_out), 32'hFFFF);
        chk("clr_empty", 32'(empty), 32'h1);
        tick();
        chk("clr_push_dropped", 32'(valid_out), 32'h0000);

        // Sparse push, then reset mid-operation with a concurrent push.
        valid_in   = 16'h0024;
        data_in[2] = 8'h5A;
        data_in[5] = 8'hC3;
        tick();
        chk("sparse_valid", 32'(valid_out), 32'h0024);
        chk("sparse_data5", 32'(data_out[5]), 32'hC3);
        rst_n    = 1'b0;
        valid_in = 16'h0020;
        tick();
        rst_n    = 1'b1;
        valid_in = '0;
        chk("midrst_valid", 32'(valid_out), 32'h0000);
        chk("midrst_empty", 32'(empty), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
